// File: rtl/gf16_seq_div_if.sv
// Request/result bundle for the sequential GF(2^4) divider.
// The requester drives start/A/B; the divider returns busy/done/Z/div_by_zero.
interface gf16_seq_div_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Z;
    logic       div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, Z, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, Z, div_by_zero
    );
endinterface

// File: rtl/gf16_seq_div.sv
// Sequential GF(2^4) divider (poly x^4+x+1): Z = A * B^14 through three square/multiply rounds.
// One shared multiplier serves both the squaring and the accumulate steps.
module gf16_seq_div (
    input  logic           clk,
    input  logic           rst,
    gf16_seq_div_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, SQ1, MUL1, SQ2, MUL2, SQ3, MUL3} state_t;

    state_t     state_reg, state_next;
    logic [3:0] acc_reg, sq_reg, z_reg;
    logic       done_reg, dbz_reg;

    logic [3:0] mul_a, mul_b, mul_p;
    logic [6:0] pp [4];
    logic [6:0] prod_raw;
    logic       sq_phase;

    // Carry-less partial products of the shared multiplier
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = mul_b[gi] ? ({3'b000, mul_a} << gi) : 7'd0;
        end
    endgenerate

    assign prod_raw = pp[0] ^ pp[1] ^ pp[2] ^ pp[3];

    // x^4 = x+1, x^5 = x^2+x, x^6 = x^3+x^2: folds never reach bit 4, so one pass suffices
    assign mul_p = prod_raw[3:0]
                 ^ (prod_raw[4] ? 4'b0011 : 4'b0000)
                 ^ (prod_raw[5] ? 4'b0110 : 4'b0000)
                 ^ (prod_raw[6] ? 4'b1100 : 4'b0000);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (bus.start && (bus.B != 4'd0)) state_next = SQ1;
            SQ1:     state_next = MUL1;
            MUL1:    state_next = SQ2;
            SQ2:     state_next = MUL2;
            MUL2:    state_next = SQ3;
            SQ3:     state_next = MUL3;
            MUL3:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sq_phase = (state_reg == SQ1) || (state_reg == SQ2) || (state_reg == SQ3);
        mul_a    = sq_phase ? sq_reg : acc_reg;
        mul_b    = sq_reg;
        bus.busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg  <= 4'd0;
            sq_reg   <= 4'd0;
            z_reg    <= 4'd0;
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.B == 4'd0) begin
                            // Zero divisor answers immediately without iterating
                            z_reg    <= 4'd0;
                            dbz_reg  <= 1'b1;
                            done_reg <= 1'b1;
                        end else begin
                            acc_reg <= bus.A;
                            sq_reg  <= bus.B;
                        end
                    end
                end
                SQ1, SQ2, SQ3: sq_reg  <= mul_p;
                MUL1, MUL2:    acc_reg <= mul_p;
                MUL3: begin
                    acc_reg  <= mul_p;
                    z_reg    <= mul_p;
                    dbz_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.done        = done_reg;
    assign bus.Z           = z_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
